vec_lane_seq: RTL and testbench
===============================

# vec_lane_seq

Vector lane sequencer between the decode/register-read stage and the ALU. It accepts one 256-bit vector instruction (VADD, VDOT or SMUL) and walks its sixteen 16-bit half-precision lanes through the ALU one lane per cycle. It captures each lane result and returns the assembled 256-bit result, or the 16-bit dot-product sum, with a done pulse. Lane arithmetic is done entirely by the ALU: this block only drives lane operands and opcodes and collects results.

## Interface
Parameters:
- LANES, 16, number of 16-bit lanes per vector. Fixed at 16 for 256-bit vectors.
- LANE_W, 16, lane width in bits.

Ports:
- clk  in  1  single clock. All state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  launches an instruction. Sampled only in IDLE.
- opcode  in  4  instruction opcode: VADD=0000, VDOT=0001, SMUL=0010. Any other value is unsupported.
- vec_a  in  256  operand 1. Lane i occupies bits [16i+15:16i]. For SMUL only lane 0 (the scalar) is used.
- vec_b  in  256  operand 2.
- lane_op_1  out  16  lane operand 1, driven to the ALU op_1[15:0].
- lane_op_2  out  16  lane operand 2, driven to the ALU op_2[15:0].
- lane_opcode  out  4  opcode driven to the ALU. Equals NOP (1111) when no lane is being issued.
- lane_result  in  16  ALU result[15:0]. The ALU is combinational, so this is valid in the same cycle as the lane it belongs to.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when result is valid.
- result  out  256  assembled result. Held until the next accepted start.

## Operation
- States: IDLE, LANE, DOT_MUL, DOT_ADD, DONE.
- IDLE with start=1:
  - vec_a, vec_b and opcode are latched and the lane counter is cleared to 0.
  - VADD or SMUL goes to LANE.
  - VDOT goes to DOT_MUL and clears the accumulator to 16'h0000.
  - An unsupported opcode goes straight to DONE with result=0.
- LANE:
  - lane_op_1 is a[i] for VADD, or a[0] for SMUL; lane_op_2 is b[i].
  - lane_opcode is the latched opcode.
  - On the clock edge, result lane i ← lane_result and the counter increments.
  - After lane 15 the block moves to DONE.
- DOT_MUL: lane_op_1=a[i], lane_op_2=b[i], lane_opcode=VDOT. The product is latched into the prod register, then the block moves to DOT_ADD.
- DOT_ADD:
  - lane_op_1=acc, lane_op_2=prod, lane_opcode=VADD.
  - acc ← lane_result and the counter increments.
  - The block returns to DOT_MUL, or moves to DONE after lane 15.
- VDOT result: {240'd0, acc}.
- DONE: done=1 and busy=0 for one cycle, then IDLE.
- The lane counter is 4 bits and terminates on 15 without wrapping into a new pass.
- start while busy, or during DONE, is ignored. The latched operands do not change.
- Reset values: state=IDLE; busy=0, done=0, result=0; lane_op_1=0, lane_op_2=0; lane_opcode=1111; acc=0, prod=0; counter=0.
- rst asserted mid-instruction aborts it on that edge: no done pulse, and result is cleared to 0.

## Timing
- start is accepted on the edge ending cycle N.
- VADD/SMUL: lanes 0..15 are issued in cycles N+1..N+16; done is high in cycle N+17 (17-cycle latency).
- VDOT: lane i multiplies in cycle N+1+2i and accumulates in cycle N+2+2i; done is high in cycle N+33.
- Unsupported opcode: done is high in cycle N+1.
- busy is high from cycle N+1 until the last issue cycle.
- result becomes valid on the same edge that asserts done.
- A new start is accepted at the earliest in the IDLE cycle that follows done, so back-to-back instructions have a one-cycle gap.

## Configuration
- VSEQ_LANE_MASK_EN defined:
  - Adds input lane_mask[15:0], latched with the operands at start.
  - A masked lane (bit=0) still takes its issue cycle(s) and keeps the fixed latency.
  - For VADD/SMUL, result lane i ← a[i] and lane_opcode=NOP.
  - For VDOT, both cycles of the lane issue NOP and acc is unchanged.
- VSEQ_LANE_MASK_EN undefined: no lane_mask port, and all lanes are active.

## Test plan
The bench uses a stub ALU: VADD gives op_1+op_2, VDOT/SMUL give the low 16 bits of op_1*op_2, and any other opcode gives 0.
- Reset check: hold rst for 2 cycles, then release → busy=0, done=0, result=0, lane_opcode=1111.
- VADD: a[i]=i, b[i]=16'h0100, start in cycle 0 → done in cycle 17 and result lane i = 16'h0100+i.
- SMUL: a[0]=3, a[15:1] set to garbage, b[i]=i+1 → result lane i = 3(i+1), so lane 15 = 16'h0030; done in cycle 17.
- VDOT: a[i]=2, b[i]=3 → result = {240'd0, 16'h0060}; done in cycle 33; lane_opcode alternates 0001/0000.
- Protocol abuse:
  - start pulses during busy are ignored.
  - opcode=0110 → done in the next cycle with result=0.
  - rst asserted in cycle 8 of a VADD → no done pulse and result=0.
- With VSEQ_LANE_MASK_EN, lane_mask=16'h00FF on the VADD case → lanes 8..15 return a[i], lanes 0..7 return 16'h0100+i, and latency is still 17.

Source files
------------

// File: rtl/vec_lane_seq.sv
// Vector lane sequencer: issues 16 half-precision lanes to a combinational ALU one per cycle and assembles the result.
// Optional per-lane masking is compiled in with VSEQ_LANE_MASK_EN.
module vec_lane_seq #(
  parameter int LANES  = 16,
  parameter int LANE_W = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      start_i,
  input  logic [3:0]                opcode_i,
  input  logic [LANES*LANE_W-1:0]   vec_a_i,
  input  logic [LANES*LANE_W-1:0]   vec_b_i,
`ifdef VSEQ_LANE_MASK_EN
  input  logic [LANES-1:0]          lane_mask_i,
`endif
  output logic [LANE_W-1:0]         lane_op_1_o,
  output logic [LANE_W-1:0]         lane_op_2_o,
  output logic [3:0]                lane_opcode_o,
  input  logic [LANE_W-1:0]         lane_result_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic [LANES*LANE_W-1:0]   result_o
);

  localparam int CW = $clog2(LANES);
  localparam logic [CW-1:0] LAST_LANE = CW'(LANES - 1);

  localparam logic [3:0] OP_VADD = 4'b0000;
  localparam logic [3:0] OP_VDOT = 4'b0001;
  localparam logic [3:0] OP_SMUL = 4'b0010;
  localparam logic [3:0] OP_NOP  = 4'b1111;

  typedef logic [LANES-1:0][LANE_W-1:0] vec_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LANE,
    S_DOT_MUL,
    S_DOT_ADD,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  vec_t                a_q, a_d;
  vec_t                b_q, b_d;
  vec_t                res_q, res_d;
  logic [3:0]          op_q, op_d;
  logic [LANE_W-1:0]   acc_q, acc_d;
  logic [LANE_W-1:0]   prod_q, prod_d;
  logic                lane_act;

`ifdef VSEQ_LANE_MASK_EN
  logic [LANES-1:0]    mask_q, mask_d;
  assign lane_act = mask_q[cnt_q];
`else
  assign lane_act = 1'b1;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      op_q    <= OP_NOP;
      acc_q   <= '0;
      prod_q  <= '0;
`ifdef VSEQ_LANE_MASK_EN
      mask_q  <= '1;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      prod_q  <= prod_d;
`ifdef VSEQ_LANE_MASK_EN
      mask_q  <= mask_d;
`endif
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    a_d           = a_q;
    b_d           = b_q;
    res_d         = res_q;
    op_d          = op_q;
    acc_d         = acc_q;
    prod_d        = prod_q;
`ifdef VSEQ_LANE_MASK_EN
    mask_d        = mask_q;
`endif
    lane_op_1_o   = '0;
    lane_op_2_o   = '0;
    lane_opcode_o = OP_NOP;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          a_d   = vec_t'(vec_a_i);
          b_d   = vec_t'(vec_b_i);
          op_d  = opcode_i;
          cnt_d = '0;
          res_d = '0;
`ifdef VSEQ_LANE_MASK_EN
          mask_d = lane_mask_i;
`endif
          case (opcode_i)
            OP_VADD, OP_SMUL: state_d = S_LANE;
            OP_VDOT: begin
              acc_d   = '0;
              state_d = S_DOT_MUL;
            end
            default: state_d = S_DONE;
          endcase
        end
      end

      S_LANE: begin
        lane_op_1_o = (op_q == OP_SMUL) ? a_q[0] : a_q[cnt_q];
        lane_op_2_o = b_q[cnt_q];
        // A masked lane passes operand a through unchanged instead of the ALU result.
        if (lane_act) begin
          lane_opcode_o = op_q;
          res_d[cnt_q]  = lane_result_i;
        end else begin
          res_d[cnt_q]  = a_q[cnt_q];
        end
        if (cnt_q == LAST_LANE) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_DOT_MUL: begin
        lane_op_1_o = a_q[cnt_q];
        lane_op_2_o = b_q[cnt_q];
        if (lane_act) begin
          lane_opcode_o = OP_VDOT;
          prod_d        = lane_result_i;
        end
        state_d = S_DOT_ADD;
      end

      S_DOT_ADD: begin
        lane_op_1_o = acc_q;
        lane_op_2_o = prod_q;
        if (lane_act) begin
          lane_opcode_o = OP_VADD;
          acc_d         = lane_result_i;
        end
        if (cnt_q == LAST_LANE) begin
          res_d    = '0;
          res_d[0] = acc_d;
          state_d  = S_DONE;
        end else begin
          cnt_d   = cnt_q + CW'(1);
          state_d = S_DOT_MUL;
        end
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  assign busy_o   = (state_q == S_LANE) || (state_q == S_DOT_MUL) || (state_q == S_DOT_ADD);
  assign done_o   = (state_q == S_DONE);
  assign result_o = res_q;

endmodule

// File: tb/tb_vec_lane_seq.sv
// Directed bench for vec_lane_seq with a stub combinational ALU.
module tb_vec_lane_seq;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [3:0]   opcode;
  logic [255:0] vec_a;
  logic [255:0] vec_b;
  logic [15:0]  lane_mask;
  logic [15:0]  lane_op_1;
  logic [15:0]  lane_op_2;
  logic [3:0]   lane_opcode;
  logic [15:0]  lane_result;
  logic         busy;
  logic         done;
  logic [255:0] result;
  logic [31:0]  mult;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  vec_lane_seq dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .start_i       (start),
    .opcode_i      (opcode),
    .vec_a_i       (vec_a),
    .vec_b_i       (vec_b),
`ifdef VSEQ_LANE_MASK_EN
    .lane_mask_i   (lane_mask),
`endif
    .lane_op_1_o   (lane_op_1),
    .lane_op_2_o   (lane_op_2),
    .lane_opcode_o (lane_opcode),
    .lane_result_i (lane_result),
    .busy_o        (busy),
    .done_o        (done),
    .result_o      (result)
  );

  always_comb begin
    mult        = 32'(lane_op_1) * 32'(lane_op_2);
    lane_result = 16'h0000;
    case (lane_opcode)
      4'b0000:          lane_result = lane_op_1 + lane_op_2;
      4'b0001, 4'b0010: lane_result = mult[15:0];
      default:          lane_result = 16'h0000;
    endcase
  end

  typedef struct {
    string        name;
    logic [3:0]   op;
    logic [255:0] a;
    logic [255:0] b;
    logic [15:0]  mask;
    logic         abuse;
    logic [255:0] exp;
    int           lat;
  } vec_rec_t;

  vec_rec_t tv[7];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] exp_opc(input vec_rec_t v, input int k);
    logic [15:0] m;
    int lane;
`ifdef VSEQ_LANE_MASK_EN
    m = v.mask;
`else
    m = 16'hFFFF;
`endif
    if (k >= v.lat) return 4'b1111;
    if (v.op == 4'b0001) begin
      lane = (k - 1) / 2;
      if (!m[lane]) return 4'b1111;
      return (k % 2 == 1) ? 4'b0001 : 4'b0000;
    end
    lane = k - 1;
    return m[lane] ? v.op : 4'b1111;
  endfunction

  task automatic run(input vec_rec_t v);
    int got = -1;
    logic busy_ok = 1'b1;
    logic opc_ok  = 1'b1;
    start     = 1'b1;
    opcode    = v.op;
    vec_a     = v.a;
    vec_b     = v.b;
    lane_mask = v.mask;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) begin
        // scramble inputs to show the operands were latched at start
        start  = 1'b0;
        vec_a  = ~v.a;
        vec_b  = ~v.b;
        opcode = 4'b0110;
      end
      if (v.abuse && k == 5) start = 1'b1;
      if (v.abuse && k == 7) start = 1'b0;
      if (done) begin
        got = k;
        if (busy) busy_ok = 1'b0;
        if (lane_opcode !== 4'b1111) opc_ok = 1'b0;
        break;
      end
      if (!busy) busy_ok = 1'b0;
      if (lane_opcode !== exp_opc(v, k)) opc_ok = 1'b0;
    end
    start = 1'b0;
    chk($sformatf("%s latency", v.name), 256'(got), 256'(v.lat));
    chk($sformatf("%s result", v.name), result, v.exp);
    chk($sformatf("%s busy", v.name), 256'(busy_ok), 256'(1));
    chk($sformatf("%s lane_opcode seq", v.name), 256'(opc_ok), 256'(1));
    @(posedge clk);
    #1;
    chk($sformatf("%s result held", v.name), result, v.exp);
  endtask

  initial begin
    logic seen_done;

    // VADD ramp, with start pulses while busy
    tv[0].name = "vadd"; tv[0].op = 4'b0000; tv[0].mask = 16'hFFFF; tv[0].abuse = 1'b1; tv[0].lat = 17;
    // SMUL: scalar in lane 0, garbage elsewhere
    tv[1].name = "smul"; tv[1].op = 4'b0010; tv[1].mask = 16'hFFFF; tv[1].abuse = 1'b0; tv[1].lat = 17;
    tv[2].name = "vdot"; tv[2].op = 4'b0001; tv[2].mask = 16'hFFFF; tv[2].abuse = 1'b0; tv[2].lat = 33;
    tv[3].name = "unsup"; tv[3].op = 4'b0110; tv[3].mask = 16'hFFFF; tv[3].abuse = 1'b0; tv[3].lat = 1;
    tv[4].name = "vadd_wrap"; tv[4].op = 4'b0000; tv[4].mask = 16'hFFFF; tv[4].abuse = 1'b0; tv[4].lat = 17;
    tv[5].name = "vadd_mask"; tv[5].op = 4'b0000; tv[5].mask = 16'h00FF; tv[5].abuse = 1'b0; tv[5].lat = 17;
    tv[6].name = "vdot_ramp"; tv[6].op = 4'b0001; tv[6].mask = 16'hFFFF; tv[6].abuse = 1'b0; tv[6].lat = 33;
    for (int i = 0; i < 7; i++) begin
      tv[i].a = '0; tv[i].b = '0; tv[i].exp = '0;
    end
    for (int i = 0; i < 16; i++) begin
      tv[0].a[16*i +: 16]   = 16'(i);
      tv[0].b[16*i +: 16]   = 16'h0100;
      tv[0].exp[16*i +: 16] = 16'h0100 + 16'(i);
      tv[1].a[16*i +: 16]   = (i == 0) ? 16'd3 : (16'hDEAD ^ 16'(i));
      tv[1].b[16*i +: 16]   = 16'(i + 1);
      tv[1].exp[16*i +: 16] = 16'(3 * (i + 1));
      tv[2].a[16*i +: 16]   = 16'd2;
      tv[2].b[16*i +: 16]   = 16'd3;
      tv[3].a[16*i +: 16]   = 16'h1234;
      tv[3].b[16*i +: 16]   = 16'h5678;
      tv[4].a[16*i +: 16]   = 16'hFFFF;
      tv[4].b[16*i +: 16]   = 16'(i);
      tv[4].exp[16*i +: 16] = 16'(i) - 16'd1;
      tv[5].a[16*i +: 16]   = 16'(i);
      tv[5].b[16*i +: 16]   = 16'h0100;
`ifdef VSEQ_LANE_MASK_EN
      tv[5].exp[16*i +: 16] = (i < 8) ? (16'h0100 + 16'(i)) : 16'(i);
`else
      tv[5].exp[16*i +: 16] = 16'h0100 + 16'(i);
`endif
      tv[6].a[16*i +: 16]   = 16'(i + 1);
      tv[6].b[16*i +: 16]   = 16'(i);
    end
    tv[2].exp[15:0] = 16'h0060;
    tv[6].exp[15:0] = 16'h0550;

    rst = 1'b1; start = 1'b0; opcode = 4'b0000; vec_a = '0; vec_b = '0; lane_mask = 16'hFFFF;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("reset busy", 256'(busy), 256'(0));
    chk("reset done", 256'(done), 256'(0));
    chk("reset result", result, 256'(0));
    chk("reset lane_opcode", 256'(lane_opcode), 256'(4'b1111));

    for (int i = 0; i < 7; i++) run(tv[i]);

    // reset asserted in cycle 8 of a VADD aborts it
    start = 1'b1; opcode = 4'b0000; vec_a = tv[0].a; vec_b = tv[0].b;
    seen_done = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (done) seen_done = 1'b1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort result", result, 256'(0));
    chk("abort busy", 256'(busy), 256'(0));
    chk("abort lane_opcode", 256'(lane_opcode), 256'(4'b1111));
    for (int k = 0; k < 25; k++) begin
      @(posedge clk);
      #1;
      if (done) seen_done = 1'b1;
    end
    chk("abort no done", 256'(seen_done), 256'(0));

    // the block still runs normally after an aborted instruction
    run(tv[1]);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_mis);
    $finish;
  end

endmodule
